conv_frame_streamer: RTL and testbench
======================================

// Module: conv_frame_streamer
// PURPOSE
//  Reads a filtered RGB frame from the parallel output of the 3x3 convolution
//  stage and transmits it pixel by pixel in raster order on a valid/ready stream.
//  The stream carries start-of-frame, end-of-line and end-of-frame markers.
//  Sits between the filter block and the display/UART/DMA sink.
//  It snapshots the frame on start, so the filter input may change during transmission.
// PARAMETERS
//  H  4  number of rows (first spatial index of the frame array)
//  V  4  number of columns (second spatial index; pixels per line)
// PORTS
//  clk       in   1                  system clock, all logic on rising edge
//  rst_n     in   1                  synchronous active-low reset
//  frame     in   8 x [0:2][0:H-1][0:V-1]  filtered frame, channel/row/column, unsigned
//  start     in   1                  request transmission of current frame
//  busy      out  1                  high from accepted start until the last beat is accepted
//  done      out  1                  one-cycle pulse after the last beat is accepted
//  m_data    out  24                 {ch0,ch1,ch2} of the current pixel, ch0 in [23:16]
//  m_valid   out  1                  m_data and markers valid
//  m_ready   in   1                  sink accepts the beat when m_valid & m_ready
//  m_sof     out  1                  current beat is pixel (0,0)
//  m_eol     out  1                  current beat is the last column, j==V-1
//  m_eof     out  1                  current beat is pixel (H-1,V-1)
// BEHAVIOUR
//  - Reset (rst_n=0 at a rising edge): busy=0, done=0, m_valid=0, m_data=0.
//    Markers are 0, row/col counters are 0 and the state is IDLE.
//    Reset takes priority over every other input, including mid-frame: the
//    beat in flight is dropped with no done pulse.
//  - FSM IDLE -> SEND -> DONE -> IDLE.
//  - IDLE: on start=1, copy frame into the internal snapshot, clear i/j and go to SEND.
//    busy=1 and m_valid=1 with pixel (0,0) from the next cycle, so start-to-first-valid is 1 cycle.
//  - start is ignored in SEND and DONE. It is not queued.
//  - SEND: m_valid=1 every cycle. Outputs are driven from the registered state of
//    snapshot[ch][i][j] and the counters.
//    While m_valid=1 and m_ready=0, m_data and all markers are held stable.
//  - On a handshake: if j<V-1 then j++; else j=0 and i++.
//    The next pixel is presented the following cycle, giving one beat per cycle under
//    continuous m_ready with no bubbles.
//  - On the handshake of (H-1,V-1): go to DONE. m_valid=0 and busy=0 next cycle.
//  - DONE: done=1 for exactly one cycle, then IDLE. A start in DONE is ignored.
//  - Markers are combinational from i/j and are qualified only by m_valid:
//    m_sof = (i==0 && j==0); m_eol = (j==V-1); m_eof = (i==H-1 && j==V-1).
//  - Degenerate sizes: H=1 or V=1 are legal.
//    With H=V=1 a single beat carries sof, eol and eof together.
//  - The counters are sized $clog2 of H and V, minimum 1 bit, and never exceed H-1 / V-1.
//  - The data path does no arithmetic. Values are passed through unchanged, as
//    already clamped 0..255 by the filter.
//  - Total beats per frame = H*V. Frame cycles with m_ready held at 1 = 1 + H*V + 1 (done).
// TESTING
//  H=2,V=3, frame[c][i][j]=16*c+4*i+j, start pulse, m_ready=1 ->
//    6 beats in consecutive cycles, first m_data=24'h00_10_20, last m_data=24'h06_16_26.
//    done is high exactly 1 cycle after the eof beat.
//  Same frame, m_ready toggling 1,0,0,1,... ->
//    m_data and markers are held during ready=0, with no duplicated or skipped pixels.
//    Beat count is 6; markers are: sof on beat 0, eol on beats 2 and 5, eof on beat 5.
//  Start held high through the frame, and the frame input changed after start ->
//    exactly one frame is sent, all beats equal the snapshot taken at start, and the
//    second frame begins only after a new start in IDLE.
//  rst_n=0 for 1 cycle after beat 2 of a frame ->
//    next cycle m_valid=0, busy=0, done never pulses.
//    A new start then resends from (0,0) with m_sof=1.
//  H=1,V=1, frame=8'hFF on all channels ->
//    one beat m_data=24'hFFFFFF with sof=eol=eof=1, then done pulses.
//  Hold m_ready=0 for 20 cycles after start ->
//    m_valid stays 1 with pixel (0,0), busy=1, done=0.
//    Releasing m_ready completes the frame normally.

Source files
------------

// File: rtl/conv_frame_streamer_if.sv
// Pixel stream between the frame streamer and its sink.
// The payload is 24-bit RGB plus raster position markers.
interface conv_frame_streamer_if;
    logic [23:0] data;
    logic        valid;
    logic        ready;
    logic        sof;
    logic        eol;
    logic        eof;

    modport master (output data, valid, sof, eol, eof, input ready);
    modport slave  (input data, valid, sof, eol, eof, output ready);
endinterface

// File: rtl/conv_frame_streamer.sv
// Snapshots a filtered 3-channel frame on start.
// It then streams the frame in raster order, one pixel per accepted beat, with sof/eol/eof markers.
module conv_frame_streamer #(
    parameter int H = 4,
    parameter int V = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [0:2][0:H-1][0:V-1][7:0]     frame,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    conv_frame_streamer_if.master             m
);
    localparam int IW = (H > 1) ? $clog2(H) : 1;
    localparam int JW = (V > 1) ? $clog2(V) : 1;

    typedef enum logic [1:0] {IDLE, SEND, FIN} state_t;

    state_t                          state_p0, state_nxt;
    logic [IW-1:0]                   i_p0;
    logic [JW-1:0]                   j_p0;
    logic [0:2][0:H-1][0:V-1][7:0]   snap_p0;
    logic                            take;
    logic                            hs;
    logic                            row_end;
    logic                            last;

    assign take    = (state_p0 == IDLE) && start;
    assign hs      = (state_p0 == SEND) && m.ready;
    assign row_end = (j_p0 == JW'(V - 1));
    assign last    = row_end && (i_p0 == IW'(H - 1));

    // ---- stage p0: control state and raster counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || take) begin
            i_p0 <= '0;
            j_p0 <= '0;
        end else if (hs) begin
            if (row_end) begin
                j_p0 <= '0;
                i_p0 <= (i_p0 == IW'(H - 1)) ? '0 : i_p0 + 1'b1;
            end else begin
                j_p0 <= j_p0 + 1'b1;
            end
        end
    end

    // Snapshot is pure data; it needs no reset because outputs are gated by valid.
    always_ff @(posedge clk) begin
        if (take) begin
            snap_p0 <= frame;
        end
    end

    always_comb begin
        state_nxt = state_p0;
        case (state_p0)
            IDLE:    if (start) state_nxt = SEND;
            SEND:    if (hs && last) state_nxt = FIN;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- output: combinational from the registered state
    always_comb begin
        busy    = 1'b0;
        done    = 1'b0;
        m.valid = 1'b0;
        m.data  = '0;
        m.sof   = 1'b0;
        m.eol   = 1'b0;
        m.eof   = 1'b0;
        case (state_p0)
            SEND: begin
                busy    = 1'b1;
                m.valid = 1'b1;
                m.data  = {snap_p0[0][i_p0][j_p0], snap_p0[1][i_p0][j_p0],
                           snap_p0[2][i_p0][j_p0]};
                m.sof   = (i_p0 == '0) && (j_p0 == '0);
                m.eol   = row_end;
                m.eof   = last;
            end
            FIN:     done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_conv_frame_streamer.sv
// Bench for conv_frame_streamer: a 2x3 instance and a 1x1 instance.
// Beats are checked against a raster-order list built from the frame captured at start.
module tb_conv_frame_streamer;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [0:2][0:1][0:2][7:0] frame23;
    logic                      start23, busy23, done23;
    logic [0:2][0:0][0:0][7:0] frame11;
    logic                      start11, busy11, done11;

    conv_frame_streamer_if if23 ();
    conv_frame_streamer_if if11 ();

    conv_frame_streamer #(.H(2), .V(3)) dut23 (
        .clk(clk), .rst_n(rst_n), .frame(frame23), .start(start23),
        .busy(busy23), .done(done23), .m(if23.master));

    conv_frame_streamer #(.H(1), .V(1)) dut11 (
        .clk(clk), .rst_n(rst_n), .frame(frame11), .start(start11),
        .busy(busy11), .done(done11), .m(if11.master));

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rand_frame23();
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 3; j++)
                    frame23[c][i][j] = 8'($urandom);
    endtask

    // mode 0: ready always 1; 1: ready 1,0,0 repeating; 2: random; 3: ready 0 for 20 cycles
    task automatic frame23_run(input int mode, input bit hold_start, input bit change_frame);
        logic [23:0] expq [6];
        int  k;
        int  cyc;
        bit  rdy;
        for (int b = 0; b < 6; b++)
            expq[b] = {frame23[0][b/3][b%3], frame23[1][b/3][b%3], frame23[2][b/3][b%3]};
        start23 = 1'b1;
        step();
        if (!hold_start) start23 = 1'b0;
        if (change_frame) rand_frame23();
        k   = 0;
        cyc = 0;
        while (k < 6 && cyc < 200) begin
            chk("valid", 32'(if23.valid), 32'd1);
            chk("busy", 32'(busy23), 32'd1);
            chk("done_mid", 32'(done23), 32'd0);
            chk("data", 32'(if23.data), 32'(expq[k]));
            chk("sof", 32'(if23.sof), 32'(k == 0));
            chk("eol", 32'(if23.eol), 32'(k % 3 == 2));
            chk("eof", 32'(if23.eof), 32'(k == 5));
            case (mode)
                1:       rdy = (cyc % 3 == 0);
                2:       rdy = 1'($urandom_range(0, 1));
                3:       rdy = (cyc >= 20);
                default: rdy = 1'b1;
            endcase
            if23.ready = rdy;
            if (rdy && if23.valid === 1'b1) k++;
            cyc++;
            step();
        end
        chk("beats", 32'(k), 32'd6);
        if (mode == 0) chk("cycles", 32'(cyc), 32'd6);
        chk("valid_fin", 32'(if23.valid), 32'd0);
        chk("busy_fin", 32'(busy23), 32'd0);
        chk("done_pulse", 32'(done23), 32'd1);
        step();
        chk("done_once", 32'(done23), 32'd0);
        chk("idle_valid", 32'(if23.valid), 32'd0);
        chk("idle_busy", 32'(busy23), 32'd0);
        start23 = 1'b0;
        if23.ready = 1'b0;
        step();
        chk("idle_stays", 32'(busy23), 32'd0);
    endtask

    initial begin
        logic [23:0] expr [6];
        rst_n      = 1'b0;
        start23    = 1'b0;
        start11    = 1'b0;
        if23.ready = 1'b0;
        if11.ready = 1'b0;
        frame23    = '0;
        frame11    = '0;
        repeat (2) step();
        chk("rst_busy", 32'(busy23), 32'd0);
        chk("rst_done", 32'(done23), 32'd0);
        chk("rst_valid", 32'(if23.valid), 32'd0);
        chk("rst_data", 32'(if23.data), 32'd0);
        chk("rst_marks", 32'({if23.sof, if23.eol, if23.eof}), 32'd0);
        chk("rst_valid11", 32'(if11.valid), 32'd0);
        rst_n = 1'b1;
        step();

        // directed frame 16c+4i+j, continuous ready
        for (int c = 0; c < 3; c++)
            for (int i = 0; i < 2; i++)
                for (int j = 0; j < 3; j++)
                    frame23[c][i][j] = 8'(16 * c + 4 * i + j);
        frame23_run(0, 1'b0, 1'b0);
        frame23_run(1, 1'b0, 1'b0);

        // random frames, random backpressure, long stall, held start with frame change
        rand_frame23();
        frame23_run(2, 1'b0, 1'b0);
        rand_frame23();
        frame23_run(3, 1'b0, 1'b0);
        rand_frame23();
        frame23_run(0, 1'b1, 1'b1);
        frame23_run(2, 1'b0, 1'b0);

        // reset mid-frame after beat 2
        rand_frame23();
        for (int b = 0; b < 6; b++)
            expr[b] = {frame23[0][b/3][b%3], frame23[1][b/3][b%3], frame23[2][b/3][b%3]};
        start23 = 1'b1;
        step();
        start23 = 1'b0;
        if23.ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            chk("rst_pre_data", 32'(if23.data), 32'(expr[b]));
            step();
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("mid_rst_valid", 32'(if23.valid), 32'd0);
        chk("mid_rst_busy", 32'(busy23), 32'd0);
        chk("mid_rst_data", 32'(if23.data), 32'd0);
        chk("mid_rst_sof", 32'(if23.sof), 32'd0);
        for (int n = 0; n < 3; n++) begin
            chk("mid_rst_nodone", 32'(done23), 32'd0);
            step();
        end
        if23.ready = 1'b0;
        frame23_run(0, 1'b0, 1'b0);

        // 1x1 frame, all FF
        frame11 = '1;
        start11 = 1'b1;
        step();
        start11 = 1'b0;
        if11.ready = 1'b1;
        chk("one_valid", 32'(if11.valid), 32'd1);
        chk("one_data", 32'(if11.data), 32'hFFFFFF);
        chk("one_marks", 32'({if11.sof, if11.eol, if11.eof}), 32'd7);
        chk("one_busy", 32'(busy11), 32'd1);
        step();
        chk("one_valid_fin", 32'(if11.valid), 32'd0);
        chk("one_done", 32'(done11), 32'd1);
        step();
        chk("one_done_once", 32'(done11), 32'd0);

        // 1x1 random pixel under a short stall
        for (int c = 0; c < 3; c++) frame11[c][0][0] = 8'($urandom);
        expr[0] = {frame11[0][0][0], frame11[1][0][0], frame11[2][0][0]};
        if11.ready = 1'b0;
        start11 = 1'b1;
        step();
        start11 = 1'b0;
        frame11 = '0;
        for (int n = 0; n < 3; n++) begin
            chk("one_stall_data", 32'(if11.data), 32'(expr[0]));
            chk("one_stall_done", 32'(done11), 32'd0);
            step();
        end
        if11.ready = 1'b1;
        step();
        chk("one_done2", 32'(done11), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
